fifo_unload_fsm: RTL and testbench
==================================

FIFO_UNLOAD_FSM -- requirements
Module: fifo_unload_fsm

Interface
REQ-001 CLK  input  1  system clock; all logic on the rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-high.
REQ-003 START  input  1  single-cycle readout request.
REQ-004 SAMP_MAX  input  7  index of the last sample per channel; sampled on an accepted START.
REQ-005 FIFO_EMPTY  input  1  sample FIFO empty flag.
REQ-006 FIFO_DATA  input  12  first-word-fall-through head word; valid whenever FIFO_EMPTY=0.
REQ-007 RDENA  output  1  pop strobe; one FIFO word consumed per cycle high.
REQ-008 DOUT  output  16  registered output word.
REQ-009 DVALID  output  1  DOUT valid.
REQ-010 DREADY  input  1  downstream accept; a word transfers on a cycle with DVALID=1 and DREADY=1.
REQ-011 LAST  output  1  marks the trailer word; qualified by DVALID.
REQ-012 BUSY  output  1  readout in progress or output word pending.
REQ-013 ERR  output  1  one-cycle pulse on an underflow timeout.

Function
REQ-014 Output slot free = (DVALID=0) or (DREADY=1); DOUT, DVALID and LAST load only when the slot is free.
REQ-015 With the slot free and nothing to load, DVALID shall clear; with the slot not free, DOUT, DVALID and LAST shall hold.
REQ-016 States: Idle, Header, Data, Trailer.
REQ-017 Idle: START -> Header; latch SAMP_MAX into smax; clear ch, sample, wcnt and the error flag.
REQ-018 START outside Idle shall be ignored.
REQ-019 Header: on slot free, load DOUT = {4'hA, 5'b0, smax} -> Data.
REQ-020 Data: on slot free and FIFO_EMPTY=0, in the same cycle:
  - assert RDENA;
  - load DOUT = {1'b0, ch[2:0], FIFO_DATA};
  - increment wcnt (11 bits).
REQ-021 ch shall advance 0..5; at ch=5 it wraps to 0 and sample increments.
REQ-022 At ch=5 and sample=smax, the pop shall be the last data pop and the state moves -> Trailer.
REQ-023 RDENA shall never assert while FIFO_EMPTY=1, while the slot is not free, or outside Data.
REQ-024 Watchdog: a 10-bit counter increments on each Data cycle with FIFO_EMPTY=1.
REQ-025 The watchdog counter clears on any pop.
REQ-026 When the watchdog count reaches 1023: pulse ERR, set the error flag, and move -> Trailer.
REQ-027 Trailer: on slot free, load DOUT = {4'hE, errflag, wcnt[10:0]} with LAST=1 -> Idle.
REQ-028 Full readout = 6*(smax+1) data words; maximum 768, which fits in wcnt.
REQ-029 BUSY = (state != Idle) or DVALID.
REQ-030 START in Idle while the trailer is still pending shall be accepted; the Header word loads only when the slot frees.
REQ-031 Throughput: one word per cycle under continuous DREADY=1 and a non-empty FIFO.
REQ-032 Latency: START at cycle 0 -> header visible with DVALID=1 at cycle 2.

Reset
REQ-033 RST shall force state=Idle.
REQ-034 RST shall clear DOUT=0, DVALID=0, LAST=0, RDENA=0, ERR=0 and BUSY=0.
REQ-035 RST shall clear ch, sample, smax, wcnt, the watchdog counter and the error flag.
REQ-036 RST mid-readout shall abandon the frame with no trailer; the FIFO is not flushed.

Structure
REQ-037 Shared package fifo_unload_pkg shall hold:
  - state encoding;
  - NCH=6;
  - HDR_CODE=4'hA and TRL_CODE=4'hE;
  - WD_LIMIT=1023;
  - data width 12.
REQ-038 There shall be no sub-module; the output register stage, watchdog and counters are inline.

Verification
REQ-039 SAMP_MAX=0, FIFO preloaded with 6 words, DREADY=1, START -> expected output sequence:
  - 16'hA000;
  - 6 data words with ch=0..5;
  - 16'hE006 with LAST=1;
  - 6 RDENA pulses;
  - BUSY low afterwards.
REQ-040 SAMP_MAX=127, FIFO full, DREADY=1 -> 770 contiguous DVALID cycles; trailer 16'hE300.
REQ-041 SAMP_MAX=1, DREADY toggled 1010..., FIFO non-empty:
  - no word lost or duplicated;
  - DOUT stable while DVALID=1 and DREADY=0;
  - RDENA never high while the slot is not free;
  - trailer 16'hE00C.
REQ-042 SAMP_MAX=0, only 3 words available:
  - ERR pulses after 1023 consecutive empty cycles;
  - trailer 16'hE803.
REQ-043 START pulsed during Data -> ignored; frame word count unchanged.
REQ-044 RST asserted mid-Data -> all outputs 0 and Idle next cycle; a new START yields header 16'hA000 | SAMP_MAX.

Source files
------------

// File: rtl/fifo_unload_pkg.sv
// Shared definitions for the FIFO unload readout: state encoding, frame codes and widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_unload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_TRL  = 2'd3
  } state_t;

  localparam int NCH = 6;   // channels interleaved per sample
  localparam int DW  = 12;  // FIFO data width
  localparam int SW  = 7;   // sample index width
  localparam int CHW = 3;   // channel index width
  localparam int WCW = 11;  // frame word counter width (max 768 words)
  localparam int WDW = 10;  // watchdog width

  localparam logic [3:0]     HDR_CODE = 4'hA;
  localparam logic [3:0]     TRL_CODE = 4'hE;
  localparam logic [WDW-1:0] WD_LIMIT = 10'd1023;
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

endpackage

// File: rtl/fifo_unload_fsm.sv
// Unloads a channel-interleaved sample FIFO as a header / data / trailer frame.
// Latency: START at cycle 0 -> header on DOUT with DVALID at cycle 2; then one word per cycle.
// Backpressure: single output register, loads only when empty or accepted (DREADY); pops stall with it.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START, SAMP_MAX     readout request and last sample index (latched on accepted START)
//   FIFO_EMPTY/DATA     first-word-fall-through FIFO head; RDENA pops one word per high cycle
//   DOUT/DVALID/DREADY  registered output word with valid/ready handshake; LAST marks the trailer
//   BUSY                readout in progress or output word still pending
//   ERR                 one-cycle pulse when the FIFO stays empty too long mid-frame
module fifo_unload_fsm
  import fifo_unload_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [SW-1:0] SAMP_MAX,
  input  logic          FIFO_EMPTY,
  input  logic [DW-1:0] FIFO_DATA,
  output logic          RDENA,
  output logic [15:0]   DOUT,
  output logic          DVALID,
  input  logic          DREADY,
  output logic          LAST,
  output logic          BUSY,
  output logic          ERR
);

  state_t         state, state_nxt;
  logic [SW-1:0]  smax;
  logic [SW-1:0]  sample;
  logic [CHW-1:0] ch;
  logic [WCW-1:0] wcnt;
  logic [WDW-1:0] wd_cnt;
  logic           errflag;
  logic           err_q;

  logic           slot_free;
  logic           pop;
  logic           wd_hit;
  logic           load;
  logic           load_last;
  logic [15:0]    load_dat;

  // The output register can take a new word when it is empty or being drained this cycle.
  assign slot_free = !DVALID || DREADY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wd_hit    = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    load_dat  = '0;
    unique case (state)
      ST_IDLE: begin
        if (START) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (slot_free) begin
          load      = 1'b1;
          load_dat  = {HDR_CODE, 5'b0, smax};
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (slot_free && !FIFO_EMPTY) begin
          pop      = 1'b1;
          load     = 1'b1;
          load_dat = {1'b0, ch, FIFO_DATA};
          if (ch == CH_LAST && sample == smax) state_nxt = ST_TRL;
        end else if (FIFO_EMPTY && wd_cnt == WD_LIMIT - 10'd1) begin
          // This empty cycle takes the watchdog to its limit: abandon data, close the frame.
          wd_hit    = 1'b1;
          state_nxt = ST_TRL;
        end
      end
      ST_TRL: begin
        if (slot_free) begin
          load      = 1'b1;
          load_last = 1'b1;
          load_dat  = {TRL_CODE, errflag, wcnt};
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      smax    <= '0;
      sample  <= '0;
      ch      <= '0;
      wcnt    <= '0;
      wd_cnt  <= '0;
      errflag <= 1'b0;
      err_q   <= 1'b0;
      DOUT    <= '0;
      DVALID  <= 1'b0;
      LAST    <= 1'b0;
    end else begin
      err_q <= wd_hit;

      if (state == ST_IDLE && START) begin
        smax    <= SAMP_MAX;
        sample  <= '0;
        ch      <= '0;
        wcnt    <= '0;
        wd_cnt  <= '0;
        errflag <= 1'b0;
      end

      if (pop) begin
        wcnt   <= wcnt + 11'd1;
        wd_cnt <= '0;
        if (ch == CH_LAST) begin
          ch     <= '0;
          sample <= sample + 7'd1;
        end else begin
          ch <= ch + 3'd1;
        end
      end else if (state == ST_DATA && FIFO_EMPTY) begin
        wd_cnt <= wd_cnt + 10'd1;
      end

      if (wd_hit) errflag <= 1'b1;

      // A free slot with nothing to load drops DVALID; a stalled slot holds everything.
      if (slot_free) begin
        DVALID <= load;
        if (load) begin
          DOUT <= load_dat;
          LAST <= load_last;
        end
      end
    end
  end

  assign RDENA = pop;
  assign ERR   = err_q;
  assign BUSY  = (state != ST_IDLE) || DVALID;

endmodule

// File: tb/tb_fifo_unload_fsm.sv
// Bench for fifo_unload_fsm: FIFO model, scoreboard of expected frame words, table of frames.
// Latency: n/a.
// Backpressure: DREADY driven always-high, alternating, or random per frame.
module tb_fifo_unload_fsm;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [6:0]  SAMP_MAX = '0;
  logic        FIFO_EMPTY = 1'b1;
  logic [11:0] FIFO_DATA = '0;
  logic        RDENA;
  logic [15:0] DOUT;
  logic        DVALID;
  logic        DREADY = 1'b0;
  logic        LAST;
  logic        BUSY;
  logic        ERR;

  fifo_unload_fsm dut (
    .CLK(CLK), .RST(RST), .START(START), .SAMP_MAX(SAMP_MAX),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .RDENA(RDENA),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .LAST(LAST),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One frame: mode 0 = DREADY always 1, 1 = alternating 1010..., 2 = random.
  typedef struct {
    logic [6:0]  smax;
    int          words;
    int          mode;
    int          mid_start;
    int          rst_at;
    logic [15:0] exp_trl;
    int          exp_err;
    bit          contig;
  } vec_t;

  vec_t vecs[8];

  logic [11:0] fifo_q[$];
  logic [16:0] sb_q[$];   // {last, word}

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"},   DOUT,   0);
    chk({tag, "_dvalid"}, DVALID, 0);
    chk({tag, "_last"},   LAST,   0);
    chk({tag, "_rdena"},  RDENA,  0);
    chk({tag, "_err"},    ERR,    0);
    chk({tag, "_busy"},   BUSY,   0);
  endtask

  task automatic run_frame(input vec_t v);
    int n_exp, cyc, first_x, last_x, n_rd, n_err, empty_run;
    bit done, trl_done, prev_stall;
    logic [15:0] prev_dout;
    logic [16:0] e;

    fifo_q.delete();
    sb_q.delete();
    for (int i = 0; i < v.words; i++) fifo_q.push_back(12'($urandom_range(0, 4095)));
    n_exp = (v.words < 6 * (int'(v.smax) + 1)) ? v.words : 6 * (int'(v.smax) + 1);
    sb_q.push_back({1'b0, 4'hA, 5'b0, v.smax});
    for (int i = 0; i < n_exp; i++) sb_q.push_back({1'b0, 1'b0, 3'(i % 6), fifo_q[i]});
    sb_q.push_back({1'b1, v.exp_trl});

    done = 0; trl_done = 0; prev_stall = 0; prev_dout = '0;
    cyc = 0; first_x = -1; last_x = -1; n_rd = 0; n_err = 0; empty_run = 0;

    while (!done && cyc < 3000) begin
      @(negedge CLK);
      START    = (cyc == 0) || (v.mid_start != 0 && cyc == v.mid_start);
      // Scrambled after the request so a DUT that fails to latch SAMP_MAX is visible.
      SAMP_MAX = (cyc == 0) ? v.smax : (7'h7f ^ v.smax);
      case (v.mode)
        0:       DREADY = 1'b1;
        1:       DREADY = (cyc % 2 == 0);
        default: DREADY = 1'($urandom_range(0, 1));
      endcase
      FIFO_EMPTY = (fifo_q.size() == 0);
      FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 12'h000;
      #1;

      if (v.rst_at != 0 && cyc == v.rst_at) begin
        RST = 1'b1;
        START = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge CLK);
        #1;
        check_reset_outputs("rst_held");
        @(negedge CLK);
        RST = 1'b0;
        done = 1;
      end else if (trl_done) begin
        chk("busy_after_frame", BUSY, 0);
        done = 1;
      end else begin
        if (cyc == 1) chk("hdr_not_yet", DVALID, 0);
        if (cyc == 2) chk("hdr_latency", DVALID, 1);
        if (prev_stall) begin
          chk("stall_hold_vld", DVALID, 1);
          chk("stall_hold_dout", DOUT, prev_dout);
        end
        if (RDENA) begin
          chk("rd_nonempty", FIFO_EMPTY, 0);
          chk("rd_slot_free", (!DVALID) || DREADY, 1);
          n_rd++;
          empty_run = 0;
        end
        if (ERR) begin
          n_err++;
          chk("wd_empty_run", empty_run, 1023);
        end
        if (FIFO_EMPTY) empty_run++;

        if (DVALID && DREADY) begin
          if (first_x < 0) first_x = cyc;
          last_x = cyc;
          if (sb_q.size() == 0) begin
            chk("sb_extra_word", DOUT, 16'hFFFF);
          end else begin
            e = sb_q.pop_front();
            chk("dout", DOUT, e[15:0]);
            chk("last", LAST, e[16]);
            if (e[16]) trl_done = 1;
          end
        end

        if (RDENA && fifo_q.size() != 0) void'(fifo_q.pop_front());
        prev_stall = DVALID && !DREADY;
        prev_dout  = DOUT;
      end
      cyc++;
    end
    START = 1'b0;

    if (!done) chk("frame_timeout", 0, 1);
    if (v.rst_at == 0) begin
      chk("sb_drained", sb_q.size(), 0);
      chk("rdena_count", n_rd, n_exp);
      chk("err_count", n_err, v.exp_err);
      if (v.contig) chk("contiguous_words", last_x - first_x + 1, n_exp + 2);
    end
  endtask

  initial begin
    //                smax  words mode mid rst  trailer   err contig
    vecs[0] = '{7'd0,     6,   0,   0,  0, 16'hE006, 0, 1'b1};
    vecs[1] = '{7'd127, 768,   0,   0,  0, 16'hE300, 0, 1'b1};
    vecs[2] = '{7'd1,    12,   1,   0,  0, 16'hE00C, 0, 1'b0};
    vecs[3] = '{7'd0,     3,   0,   0,  0, 16'hE803, 1, 1'b0};
    vecs[4] = '{7'd5,    36,   2,   0,  0, 16'hE024, 0, 1'b0};
    vecs[5] = '{7'd2,    18,   0,   5,  0, 16'hE012, 0, 1'b1};
    vecs[6] = '{7'd3,    24,   0,   0,  8, 16'hE018, 0, 1'b0};
    vecs[7] = '{7'd3,    24,   0,   0,  0, 16'hE018, 0, 1'b1};

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);

    for (int k = 0; k < 8; k++) run_frame(vecs[k]);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
